// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - switch/button program loader feeding the cpu instruction memory write port
module prog_loader #(
  parameter int                ADDR_W          = 6,
  parameter int                DATA_W          = 16,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter logic [DATA_W-1:0] END_WORD        = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] switches,
  input  logic              load_btn,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              loading,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  // Counter just wide enough to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state;
  logic               sync1;
  logic               sync2;
  logic [CNT_W-1:0]   db_cnt;
  logic               db_level;
  logic               db_prev;
  logic               press;
  logic [ADDR_W:0]    next_count;

  // Two-flop synchronizer: load_btn is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= load_btn;
      sync2 <= sync1;
    end
  end

  // Debounce: the level only follows s after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync2 != db_level) begin
      if (db_cnt == CNT_MAX) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= 1'b0;
    end else begin
      db_prev <= db_level;
    end
  end

  // One pulse per debounced press, no matter how long the button is held.
  assign press      = db_level & ~db_prev;
  assign next_count = word_count + {{ADDR_W{1'b0}}, 1'b1};

  // Loader FSM: writes one word per press, leaves LOAD on END_WORD or when memory is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_rst    <= 1'b1;
      loading    <= 1'b1;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (press) begin
            if (switches == END_WORD) begin
              state   <= ST_RUN;
              cpu_rst <= 1'b0;
              loading <= 1'b0;
              done    <= 1'b1;
            end else begin
              im_we      <= 1'b1;
              im_addr    <= word_count[ADDR_W-1:0];
              im_wdata   <= switches;
              word_count <= next_count;
              // Top bit set means this write fills the last address.
              if (next_count[ADDR_W]) begin
                state   <= ST_RUN;
                cpu_rst <= 1'b0;
                loading <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          cpu_rst <= 1'b0;
          loading <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int DB     = 16;
  localparam logic [15:0] END_W = 16'hFFFF;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] switches;
  logic              load_btn;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_rst;
  logic              loading;
  logic              done;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;

  // Reference model: loader state as seen from outside.
  int  m_count = 0;
  bit  m_run   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] got_q[$];
  logic prev_we = 1'b0;

  prog_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEBOUNCE_CYCLES(DB),
    .END_WORD(END_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switches(switches),
    .load_btn(load_btn),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_rst(cpu_rst),
    .loading(loading),
    .done(done),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: records every write and checks pulse width.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      check("we_width", 32'(prev_we), 32'd0);
      got_q.push_back({im_addr, im_wdata});
      if (im_addr == 6'd63) check("full_run_same_cycle", 32'(done), 32'd1);
    end
    prev_we = im_we;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_press(input logic [15:0] data);
    if (!m_run) begin
      if (data == END_W) begin
        m_run = 1;
      end else begin
        exp_q.push_back({6'(m_count), data});
        m_count++;
        if (m_count == DEPTH) m_run = 1;
      end
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_run   = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // A press registers only if the button stays high well beyond the debounce window.
  task automatic press(input logic [15:0] data, input int hold, input bit bounce, input bit change);
    switches = data;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        load_btn = (i % 2 == 0);
        cyc(3);
      end
    end
    load_btn = 1'b1;
    if (change && hold > 100) begin
      cyc(100);
      switches = data ^ 16'h0F0F;
      cyc(hold - 100);
    end else begin
      cyc(hold);
    end
    load_btn = 1'b0;
    cyc(24);
    if (hold >= DB + 4) model_press(data);
  endtask

  task automatic check_state(input string tag);
    while (exp_q.size() > 0) begin
      logic [ADDR_W+DATA_W-1:0] e;
      logic [ADDR_W+DATA_W-1:0] g;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check({tag, "_write_missing"}, 32'(got_q.size()), 32'd1);
      end else begin
        g = got_q.pop_front();
        check({tag, "_addr"}, 32'(g[21:16]), 32'(e[21:16]));
        check({tag, "_data"}, 32'(g[15:0]), 32'(e[15:0]));
      end
    end
    check({tag, "_extra_writes"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
    check({tag, "_word_count"}, 32'(word_count), 32'(m_count));
    check({tag, "_done"}, 32'(done), 32'(m_run));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!m_run));
    check({tag, "_loading"}, 32'(loading), 32'(!m_run));
  endtask

  // Asserts rst between clock edges and checks outputs before any further edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_im_we"}, 32'(im_we), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_loading"}, 32'(loading), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    load_btn = 1'b0;
    #3;
    rst = 1'b0;
    model_reset();
    cyc(24);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] d;
    d = 16'($urandom);
    while (d == END_W) d = 16'($urandom);
    return d;
  endfunction

  initial begin
    rst      = 1'b1;
    load_btn = 1'b0;
    switches = '0;
    cyc(3);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_loading", 32'(loading), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    cyc(5);

    // Directed three-word program then terminator.
    press(16'h1234, 30, 0, 0);
    press(16'hABCD, 30, 0, 0);
    press(16'h0001, 30, 0, 0);
    check_state("three_words");
    press(END_W, 30, 0, 0);
    check_state("end_press");
    press(rand_word(), 40, 0, 0);
    check_state("run_ignores_press");

    async_reset("reset_in_run");
    check_state("after_run_reset");

    // Random clean presses.
    for (int i = 0; i < int'($urandom_range(3, 6)); i++) begin
      press(rand_word(), int'($urandom_range(30, 60)), 0, 0);
    end
    check_state("random_clean");

    press(rand_word(), 40, 1, 0);
    check_state("bouncy");
    press(rand_word(), 10, 0, 0);
    check_state("glitch");
    press(rand_word(), 500, 0, 1);
    check_state("long_hold");

    // Reset in the middle of a debounce count.
    load_btn = 1'b1;
    cyc(8);
    async_reset("reset_mid_debounce");
    press(rand_word(), 35, 0, 0);
    check_state("after_debounce_reset");

    // Terminator as the very first press.
    cyc(1);
    async_reset("reset_before_end_first");
    press(END_W, 30, 0, 0);
    check_state("end_first");

    // Fill the whole memory, then one more press.
    cyc(1);
    async_reset("reset_before_fill");
    for (int i = 0; i < DEPTH; i++) begin
      press(16'(i), 24, 0, 0);
    end
    check_state("fill_64");
    press(16'h5555, 30, 0, 0);
    check_state("press_65");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Front-end program loader that sits directly upstream of the cpu instruction memory write port.
- Captures 16-bit instruction words from the board switches, one word per debounced press of a load button.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the cpu in reset until the program is terminated, then releases it so execution starts from PC 0.

Parameters:
ADDR_W, 6, instruction memory address width (matches the 6-bit PC; depth = 2**ADDR_W = 64)
DATA_W, 16, instruction word width (matches switches)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced button level changes (bench value; board build overrides to ~1_000_000)
END_WORD, 16'hFFFF, switch value that terminates loading when pressed; it is never written

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
switches  input  DATA_W  instruction word to load, sampled on the press cycle
load_btn  input  1  raw, asynchronous, bouncy load push-button
im_we  output  1  instruction memory write enable, single-cycle pulse
im_addr  output  ADDR_W  instruction memory write address
im_wdata  output  DATA_W  instruction memory write data
cpu_rst  output  1  held high while loading; drives the cpu rst input
loading  output  1  high in LOAD state
done  output  1  high in RUN state
word_count  output  ADDR_W+1  number of words written so far (0..64)

Behaviour:
- Reset (async, rst=1): state=LOAD, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, loading=1, done=0, word_count=0. Synchronizer, debounce counter and debounced level are cleared to 0. Instruction memory contents are not touched.
- Button path:
  - 2-flop synchronizer on load_btn, output s.
  - Debounce: while s != db_level the counter increments; when it reaches DEBOUNCE_CYCLES-1, db_level<=s and the counter clears. Any cycle with s == db_level clears the counter.
  - press = db_level rising edge, one-cycle pulse. Holding the button yields exactly one press. Glitches shorter than DEBOUNCE_CYCLES never change db_level.
- States: LOAD, RUN.
- LOAD, press at cycle N:
  - If switches == END_WORD: go to RUN at N+1 with no write.
  - Otherwise, at N+1: im_we=1, im_addr=word_count (value at N), im_wdata=switches (sampled at N), and word_count increments.
  - im_we returns to 0 at N+2. im_addr and im_wdata hold their last values between writes.
  - If the write went to address 2**ADDR_W-1, go to RUN in the same cycle im_we is high (word_count=64).
- LOAD with no press: outputs static, cpu_rst=1.
- RUN: cpu_rst=0, loading=0, done=1, im_we=0. All presses and switch changes are ignored. Only rst returns the block to LOAD.
- cpu_rst deasserts on the first RUN cycle; the cpu sees its first non-reset edge one cycle later.
- Simultaneous events:
  - rst asserted mid-debounce or on a write cycle: the write is aborted (im_we forced 0 asynchronously) and all state clears.
  - A press arriving while a write is in flight cannot happen, because the debounce guarantees at least DEBOUNCE_CYCLES between presses.
- Memory full: after 64 words the block is in RUN; a 65th press is ignored, word_count stays 64 and no wrap-around to address 0 occurs.
- Address/count arithmetic is unsigned. word_count is ADDR_W+1 bits so that the value 64 is representable; im_addr = word_count[ADDR_W-1:0].

Test Plan:
- Reset, then load 3 words 16'h1234, 16'hABCD, 16'h0001 with clean presses, then END_WORD -> im_we pulses at addresses 0, 1, 2 with matching data, each exactly one cycle wide; word_count=3; done=1, cpu_rst=0 after the END press.
- Bouncy press: toggle load_btn every 3 cycles for 30 cycles, then hold high 40 cycles (DEBOUNCE_CYCLES=16) -> exactly one im_we pulse; a 10-cycle glitch alone -> no write.
- Held button for 500 cycles with switches changing mid-hold -> one write, carrying data sampled on the press cycle.
- 64 presses with switches=i -> addresses 0..63 written, RUN entered on the 64th write, word_count=64; a 65th press produces no im_we.
- Assert rst for 1 cycle asynchronously (between clock edges) during a debounce count and during RUN -> outputs return immediately to reset values (cpu_rst=1, word_count=0), and the next load writes address 0.
- END_WORD as the first press -> RUN with word_count=0 and no im_we ever asserted.
